// File: rtl/ads412x_spi_responder.sv
// Receiving end of the ADS412x 3-wire configuration link: oversamples SEN/SCLK/SDATA,
// deframes 16-bit address/data words and commits them to a local register file.
module ads412x_spi_responder #(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       spi_sen,
    input  logic       spi_sclk,
    input  logic       spi_sdata,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       addr_err,
    output logic [7:0] frame_err_cnt,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        WAIT_HIGH,
        IDLE,
        SHIFT,
        COMMIT
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sen_sync_q, sclk_sync_q, sdata_sync_q;
    logic                   sen_prev_q, sclk_prev_q;
    logic                   sen_s, sclk_s, sdata_s;
    logic                   sen_fall, sen_rise, sclk_fall;

    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  err_q, err_d;
    logic        wr_valid_q, wr_valid_d;
    logic        addr_err_q, addr_err_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  regs_q [NUM_REGS];

    // Synchronizers reset low so a reset inside a SEN-low window never fakes a falling edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sen_sync_q   <= '0;
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            sen_prev_q   <= 1'b0;
            sclk_prev_q  <= 1'b0;
        end else begin
            sen_sync_q   <= {sen_sync_q[SYNC_STAGES-2:0], spi_sen};
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], spi_sdata};
            sen_prev_q   <= sen_s;
            sclk_prev_q  <= sclk_s;
        end
    end

    assign sen_s     = sen_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];
    assign sen_fall  = sen_prev_q & ~sen_s;
    assign sen_rise  = ~sen_prev_q & sen_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_HIGH;
            shift_q    <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            wr_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            wr_valid_q <= wr_valid_d;
            addr_err_q <= addr_err_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        wr_valid_d = 1'b0;
        addr_err_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        unique case (state_q)
            WAIT_HIGH: begin
                if (sen_s) state_d = IDLE;
            end
            IDLE: begin
                if (sen_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_fall) begin
                    shift_d = {shift_q[14:0], sdata_s};
                    cnt_d   = cnt_q + 5'd1;
                end
                // The 16th edge wins over a coincident SEN rise: the word is complete.
                if (sclk_fall && cnt_q == 5'd15) begin
                    state_d = COMMIT;
                end else if (sen_rise) begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                wr_valid_d = 1'b1;
                wr_addr_d  = shift_q[15:8];
                wr_data_d  = shift_q[7:0];
                addr_err_d = ({1'b0, shift_q[15:8]} >= 9'(NUM_REGS));
                state_d    = WAIT_HIGH;
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

    // Register file is written from the latched word, so it reads back the cycle after wr_valid.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[AW'(i)] <= '0;
        end else if (wr_valid_q && !addr_err_q) begin
            regs_q[wr_addr_q[AW-1:0]] <= wr_data_q;
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < 9'(NUM_REGS)) rd_data = regs_q[rd_addr[AW-1:0]];
    end

    assign wr_valid      = wr_valid_q;
    assign addr_err      = addr_err_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign frame_err_cnt = err_q;
    assign busy          = (state_q == SHIFT);

endmodule

// File: tb/tb_ads412x_spi_responder.sv
// Randomized frame-level bench for ads412x_spi_responder with a word/register reference model.
module tb_ads412x_spi_responder;

    localparam int unsigned NREGS = 32;
    localparam int unsigned SS    = 2;

    logic       clk = 1'b0;
    logic       rst_n, sen, sclk, sdata;
    logic [7:0] rd_addr;
    logic       wr_valid, addr_err, busy;
    logic [7:0] wr_addr, wr_data, frame_err_cnt, rd_data;

    always #5 clk = ~clk;

    ads412x_spi_responder #(.NUM_REGS(NREGS), .SYNC_STAGES(SS)) dut (
        .clk_in       (clk),
        .rst_n        (rst_n),
        .spi_sen      (sen),
        .spi_sclk     (sclk),
        .spi_sdata    (sdata),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .addr_err     (addr_err),
        .frame_err_cnt(frame_err_cnt),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Observed writes
    logic [7:0] obs_addr[$];
    logic [7:0] obs_data[$];
    logic [7:0] obs_post[$];
    logic       obs_aerr[$];
    int         obs_cyc[$];
    logic       post_pend = 1'b0;
    logic       prev_wv   = 1'b0;

    always @(negedge clk) begin
        if (post_pend) obs_post.push_back(rd_data);
        post_pend <= wr_valid;
        prev_wv   <= wr_valid;
        if (wr_valid) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
            obs_aerr.push_back(addr_err);
            obs_cyc.push_back(cyc);
            chk("wv_single", 32'(prev_wv), 32'd0);
        end else if (addr_err) begin
            chk("aerr_alone", 32'(addr_err), 32'd0);
        end
    end

    // Reference model
    logic [7:0] mregs[NREGS];
    int         merr;

    task automatic model_reset();
        for (int i = 0; i < int'(NREGS); i++) mregs[i] = 8'h00;
        merr = 0;
    endtask

    function automatic logic [7:0] mread(input logic [7:0] a);
        if (32'(a) < NREGS) return mregs[a[4:0]];
        return 8'h00;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bits are MSB-first from bit 31; the first 16 form the word
    task automatic run_frame(input logic [31:0] bits, input int nbits, input bit sim_rise);
        int          n0;
        int          fall16;
        logic [15:0] w;
        bit          commit;
        w      = bits[31:16];
        commit = (nbits >= 16);
        n0     = obs_addr.size();
        fall16 = 0;
        rd_addr = commit ? w[15:8] : 8'($urandom_range(0, 47));
        tick(1);
        sen = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            sdata = bits[31-i];
            sclk  = 1'b1;
            tick(4);
            sclk = 1'b0;
            if (i == 15) fall16 = cyc;
            if (sim_rise && i == nbits - 1) sen = 1'b1;
            if (i == 1) chk("busy_mid", 32'(busy), 32'd1);
            tick(4);
        end
        sen = 1'b1;
        tick(8);
        if (commit) begin
            chk("nwr", 32'(obs_addr.size() - n0), 32'd1);
            if (obs_addr.size() > n0 && obs_post.size() > n0) begin
                chk("wr_addr", 32'(obs_addr[n0]), 32'(w[15:8]));
                chk("wr_data", 32'(obs_data[n0]), 32'(w[7:0]));
                chk("addr_err", 32'(obs_aerr[n0]), 32'(32'(w[15:8]) >= NREGS));
                chk("latency", 32'(obs_cyc[n0] - fall16), 32'(SS + 2));
                if (32'(w[15:8]) < NREGS) mregs[w[12:8]] = w[7:0];
                chk("rd_after_wv", 32'(obs_post[n0]), 32'(mread(w[15:8])));
            end
        end else begin
            chk("nwr", 32'(obs_addr.size() - n0), 32'd0);
            if (merr < 255) merr++;
        end
        chk("errcnt", 32'(frame_err_cnt), 32'(merr));
        chk("busy_idle", 32'(busy), 32'd0);
        repeat (2) begin
            rd_addr = 8'($urandom_range(0, 47));
            #1;
            chk("rd", 32'(rd_data), 32'(mread(rd_addr)));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n   = 1'b0;
        sen     = 1'b1;
        sclk    = 1'b0;
        sdata   = 1'b0;
        rd_addr = 8'h00;
        model_reset();
        tick(3);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_errcnt", 32'(frame_err_cnt), 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Basic word, out-of-range word, abort then good word, overlong frame, coincident SEN rise
        run_frame({16'h03A5, 16'h0000}, 16, 1'b0);
        rd_addr = 8'h03; #1;
        chk("t1_rd3", 32'(rd_data), 32'hA5);
        run_frame({16'h4011, 16'h0000}, 16, 1'b0);
        rd_addr = 8'h40; #1;
        chk("t2_rd40", 32'(rd_data), 32'h00);
        run_frame({16'h1234, 16'h0000}, 9, 1'b0);
        chk("t3_err1", 32'(frame_err_cnt), 32'd1);
        run_frame({16'h01FF, 16'h0000}, 16, 1'b0);
        run_frame({16'h053C, 16'hABCD}, 20, 1'b0);
        run_frame({16'h075A, 16'h0000}, 16, 1'b1);

        // Reset after 8 bits, finish the frame with SEN still low: nothing commits
        n0 = obs_addr.size();
        sen = 1'b0;
        tick(4);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                rst_n = 1'b0;
                tick(2);
                model_reset();
                chk("mid_rst_busy", 32'(busy), 32'd0);
                chk("mid_rst_rd3", 32'(rd_data), 32'd0);
                rst_n = 1'b1;
                tick(2);
            end
            sdata = (i % 3) == 0;
            sclk  = 1'b1;
            tick(4);
            sclk = 1'b0;
            tick(4);
        end
        sen = 1'b1;
        tick(8);
        chk("mid_rst_nwr", 32'(obs_addr.size() - n0), 32'd0);
        chk("mid_rst_errcnt", 32'(frame_err_cnt), 32'd0);
        run_frame({16'h0277, 16'h0000}, 16, 1'b0);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            logic [31:0] bits;
            int          nb;
            int unsigned sel;
            bits = $urandom();
            if ($urandom_range(0, 3) != 0) bits[31:24] = 8'($urandom_range(0, 40));
            sel = $urandom_range(0, 19);
            if (sel < 14)      nb = 16;
            else if (sel < 17) nb = int'($urandom_range(0, 15));
            else               nb = int'($urandom_range(17, 20));
            run_frame(bits, nb, (nb == 16) && ($urandom_range(0, 9) == 0));
        end

        // Saturate the aborted-frame counter
        for (int f = 0; f < 256; f++) run_frame($urandom(), int'($urandom_range(0, 3)), 1'b0);
        chk("err_sat", 32'(frame_err_cnt), 32'd255);
        run_frame({16'h1F42, 16'h0000}, 16, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
